// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the 3x3 convolution window generator.
//   DATA_W      default pixel/tap width
//   TAPS        number of taps in a 3x3 window
//   TAP_*       tap indices, k = 3*dr + dc (dr/dc = 0..2 for offsets -1..+1)
//   MASK_*      taps that fall outside the image on each frame edge
//   state_t     window generator control states
//   edge_mask() in-image tap mask for a window centre on the given edges
package conv_pkg;

  localparam int DATA_W = 10;
  localparam int TAPS   = 9;

  localparam int TAP_TL = 0;
  localparam int TAP_T  = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_L  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_R  = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_B  = 7;
  localparam int TAP_BR = 8;

  localparam logic [TAPS-1:0] MASK_TOP   = 9'h007;
  localparam logic [TAPS-1:0] MASK_BOT   = 9'h1C0;
  localparam logic [TAPS-1:0] MASK_LEFT  = 9'h049;
  localparam logic [TAPS-1:0] MASK_RIGHT = 9'h124;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_FLUSH
  } state_t;

  function automatic logic [TAPS-1:0] edge_mask(input logic top, input logic bot,
                                                input logic left, input logic right);
    logic [TAPS-1:0] m;
    m = '1;
    if (top)   m &= ~MASK_TOP;
    if (bot)   m &= ~MASK_BOT;
    if (left)  m &= ~MASK_LEFT;
    if (right) m &= ~MASK_RIGHT;
    return m;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: circular line buffer acting as a DEPTH-step delay line.
//   Each enabled cycle writes i_din at the write pointer and advances it.
//   o_dout is registered and always holds the oldest entry, i.e. the value
//   written DEPTH enabled cycles ago, ready for the next enabled cycle.
// Ports:
//   i_clk   clock
//   i_rst   asynchronous active-high reset (clears pointer and output)
//   i_en    shift enable
//   i_din   value written this shift
//   o_dout  value written DEPTH shifts earlier
module conv_line_buffer #(
  parameter int DEPTH  = 28,
  parameter int DATA_W = conv_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_nxt;

  assign ptr_nxt = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;

  // Prefetch the entry after the one being overwritten, so o_dout is the
  // oldest value when the next shift arrives. DEPTH >= 3 keeps ptr_nxt != ptr.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr    <= '0;
      o_dout <= '0;
    end else if (i_en) begin
      ptr    <= ptr_nxt;
      o_dout <= mem[ptr_nxt];
    end
  end

  // NOTE: the storage array is deliberately not reset; stale entries only
  // ever reach window taps that the edge mask marks as padding.
  always_ff @(posedge i_clk) begin
    if (i_en) mem[ptr] <= i_din;
  end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator for stride-1 "same" convolution.
//   Every shift pushes one column {row-2, row-1, row} into the 3x3 tap registers;
//   after the shift for stream position p the window is centred on position
//   p-(IMG_W+1). After the last pixel, IMG_W+1 dummy zero columns drain the frame.
// Ports:
//   i_clk     clock
//   i_rst     asynchronous active-high reset
//   i_valid   input pixel valid
//   o_ready   pixel accepted when i_valid & o_ready
//   i_pixel   raster-order input pixel
//   o_valid   o_window/o_mask/o_last valid
//   i_ready   window accepted when o_valid & i_ready
//   o_window  tap k at [k*DATA_W +: DATA_W], k = 3*dr + dc
//   o_mask    bit k set when tap k lies inside the image
//   o_last    marks the window centred on (IMG_H-1, IMG_W-1)
module conv_window_gen #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic [DATA_W-1:0]                    i_pixel,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [conv_pkg::TAPS*DATA_W-1:0]     o_window,
  output logic [conv_pkg::TAPS-1:0]            o_mask,
  output logic                                 o_last
);
  import conv_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t            state;
  state_t            state_nxt;
  logic [RW-1:0]     in_row;
  logic [CW-1:0]     in_col;
  logic [RW-1:0]     out_row;
  logic [CW-1:0]     out_col;
  logic [DATA_W-1:0] taps [TAPS];
  logic [DATA_W-1:0] col_top;
  logic [DATA_W-1:0] col_mid;
  logic [DATA_W-1:0] col_bot;
  logic              slot_free;
  logic              in_acc;
  logic              flush_step;
  logic              step;
  logic              produce;

  // The output register may be overwritten only when empty or being consumed;
  // a shift always overwrites it, so input is throttled on the same condition.
  assign slot_free = !o_valid || i_ready;
  assign o_ready   = !i_rst && (state != ST_FLUSH) && slot_free;
  assign in_acc    = i_valid && o_ready;
  assign step      = in_acc || flush_step;
  assign col_bot   = in_acc ? i_pixel : '0;

  // Two chained delay lines give the same column one and two rows earlier.
  conv_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb_mid (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (step),
    .i_din  (col_bot),
    .o_dout (col_mid)
  );

  conv_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb_top (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (step),
    .i_din  (col_mid),
    .o_dout (col_top)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    produce    = 1'b0;
    flush_step = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (in_acc) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        // Pixel (1,1) completes window (0,0).
        if (in_acc && in_row == RW'(1) && in_col == CW'(1)) begin
          produce   = 1'b1;
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        produce = in_acc;
        if (in_acc && in_row == ROW_LAST && in_col == COL_LAST) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Keep shifting dummy columns until the last window sits in the output.
        flush_step = slot_free && !(o_valid && o_last);
        produce    = flush_step;
        if (o_valid && o_last && i_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, making the tap shift order-independent.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      in_row  <= '0;
      in_col  <= '0;
      out_row <= '0;
      out_col <= '0;
      o_valid <= 1'b0;
      o_mask  <= '0;
      o_last  <= 1'b0;
      for (int k = 0; k < TAPS; k++) taps[k] <= '0;
    end else begin
      if (in_acc) begin
        if (in_col == COL_LAST) begin
          in_col <= '0;
          in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end

      if (step) begin
        taps[TAP_TL] <= taps[TAP_T];
        taps[TAP_T]  <= taps[TAP_TR];
        taps[TAP_TR] <= col_top;
        taps[TAP_L]  <= taps[TAP_C];
        taps[TAP_C]  <= taps[TAP_R];
        taps[TAP_R]  <= col_mid;
        taps[TAP_BL] <= taps[TAP_B];
        taps[TAP_B]  <= taps[TAP_BR];
        taps[TAP_BR] <= col_bot;

        o_valid <= produce;
        if (produce) begin
          // The column shifted in on the right edge wraps from the next row;
          // the right-edge mask hides it.
          o_mask <= edge_mask(out_row == '0, out_row == ROW_LAST,
                              out_col == '0, out_col == COL_LAST);
          o_last <= (out_row == ROW_LAST) && (out_col == COL_LAST);
          if (out_col == COL_LAST) begin
            out_col <= '0;
            out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
          end else begin
            out_col <= out_col + 1'b1;
          end
        end
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    o_window = '0;
    for (int k = 0; k < TAPS; k++) o_window[k*DATA_W +: DATA_W] = taps[k];
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: self-checking bench for conv_window_gen on a 4x4 frame.
//   A monitor records every accepted pixel and, on every cycle o_valid is high,
//   derives the expected window, mask and last flag directly from the pixel
//   grid and the window index. Literal expectations pin selected windows.
module tb_conv_window_gen;

  localparam int DW   = 10;
  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int NPIX = IW * IH;

  logic            clk;
  logic            rst;
  logic            i_valid;
  logic            o_ready;
  logic [DW-1:0]   i_pixel;
  logic            o_valid;
  logic            i_ready;
  logic [9*DW-1:0] o_window;
  logic [8:0]      o_mask;
  logic            o_last;

  int n_vec = 0;
  int n_err = 0;

  int in_cnt  = 0;
  int out_cnt = 0;
  logic [DW-1:0] acc [2][NPIX];

  logic [9*DW-1:0] cap_win  [NPIX];
  logic [8:0]      cap_mask [NPIX];
  logic            cap_last [NPIX];

  logic            stalled = 1'b0;
  logic [9*DW-1:0] held_win;
  logic [8:0]      held_mask;
  logic            held_last;

  conv_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_pixel  (i_pixel),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_window (o_window),
    .o_mask   (o_mask),
    .o_last   (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected window from the accepted pixel grid: tap k covers (r+dr-1, c+dc-1).
  task automatic compare_window();
    int fr, n, r, c, req, rr, cc;
    logic [8:0] m;
    fr = out_cnt / NPIX;
    n  = out_cnt % NPIX;
    r  = n / IW;
    c  = n % IW;
    req = fr * NPIX + ((r + 1 > IH - 1) ? IH - 1 : r + 1) * IW
        + ((c + 1 > IW - 1) ? IW - 1 : c + 1) + 1;
    check($sformatf("early w%0d", n), 32'(in_cnt >= req), 32'd1);
    m = '0;
    for (int k = 0; k < 9; k++) begin
      rr = r + k / 3 - 1;
      cc = c + k % 3 - 1;
      if (rr >= 0 && rr < IH && cc >= 0 && cc < IW) begin
        m[k] = 1'b1;
        check($sformatf("w%0d tap%0d", n, k), 32'(o_window[k*DW +: DW]),
              32'(acc[fr % 2][rr * IW + cc]));
      end
    end
    check($sformatf("w%0d mask", n), 32'(o_mask), 32'(m));
    check($sformatf("w%0d last", n), 32'(o_last), 32'(n == NPIX - 1));
    cap_win[n]  = o_window;
    cap_mask[n] = o_mask;
    cap_last[n] = o_last;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_cnt  = 0;
        out_cnt = 0;
        stalled = 1'b0;
      end else begin
        if (stalled)
          check("hold stable", 32'((o_window === held_win) && (o_mask === held_mask)
                && (o_last === held_last) && o_valid), 32'd1);
        stalled   = o_valid && !i_ready;
        held_win  = o_window;
        held_mask = o_mask;
        held_last = o_last;
        if (o_valid) begin
          compare_window();
          if (i_ready) out_cnt++;
        end
        if (in_cnt > 0 && in_cnt % NPIX == 0 && out_cnt < in_cnt)
          check("ready low in flush", 32'(o_ready), 32'd0);
        if (i_valid && o_ready) begin
          acc[(in_cnt / NPIX) % 2][in_cnt % NPIX] = i_pixel;
          in_cnt++;
        end
      end
    end
  end

  task automatic send_pixel(input int v);
    logic got;
    int guard;
    got   = 1'b0;
    guard = 0;
    i_valid = 1'b1;
    i_pixel = DW'(v);
    while (!got && guard < 300) begin
      @(negedge clk);
      got = o_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!got) check("pixel accept timeout", 32'd0, 32'd1);
    i_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int i = 0; i < NPIX; i++) begin
      send_pixel(base + i + 1);
      if (gaps) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_out(input int target);
    int guard;
    guard = 0;
    while (out_cnt < target && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("window count", 32'(out_cnt), 32'(target));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst o_valid",  32'(o_valid),   32'd0);
    check("rst o_last",   32'(o_last),    32'd0);
    check("rst o_window", 32'(|o_window), 32'd0);
    check("rst o_mask",   32'(o_mask),    32'd0);
    check("rst o_ready",  32'(o_ready),   32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready after reset", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Hand-computed windows of a frame whose pixel (r,c) is base + 4r + c + 1.
  task automatic check_literals(input int base);
    int w5 [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    int w6 [9] = '{2, 3, 4, 6, 7, 8, 10, 11, 12};
    check("lit w0 tap4", 32'(cap_win[0][4*DW +: DW]), 32'(base + 1));
    check("lit w0 tap5", 32'(cap_win[0][5*DW +: DW]), 32'(base + 2));
    check("lit w0 tap7", 32'(cap_win[0][7*DW +: DW]), 32'(base + 5));
    check("lit w0 tap8", 32'(cap_win[0][8*DW +: DW]), 32'(base + 6));
    check("lit w0 mask", 32'(cap_mask[0]), 32'h1B0);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("lit w5 tap%0d", k), 32'(cap_win[5][k*DW +: DW]), 32'(base + w5[k]));
      check($sformatf("lit w6 tap%0d", k), 32'(cap_win[6][k*DW +: DW]), 32'(base + w6[k]));
    end
    check("lit w5 mask", 32'(cap_mask[5]), 32'h1FF);
    check("lit w15 tap0", 32'(cap_win[15][0*DW +: DW]), 32'(base + 11));
    check("lit w15 tap1", 32'(cap_win[15][1*DW +: DW]), 32'(base + 12));
    check("lit w15 tap3", 32'(cap_win[15][3*DW +: DW]), 32'(base + 15));
    check("lit w15 tap4", 32'(cap_win[15][4*DW +: DW]), 32'(base + 16));
    check("lit w15 mask", 32'(cap_mask[15]), 32'h01B);
    check("lit w15 last", 32'(cap_last[15]), 32'd1);
    check("lit w3 mask",  32'(cap_mask[3]),  32'h0D8);
    check("lit w12 mask", 32'(cap_mask[12]), 32'h036);
    check("lit w11 mask", 32'(cap_mask[11]), 32'h0DB);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no end of stimulus, expected completion before 50000 ns");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_pixel = '0;
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    check_reset_outputs();
    release_reset();

    // Full frame at full rate.
    send_frame(0, 1'b0);
    wait_out(NPIX);
    check_literals(0);
    @(negedge clk);
    check("ready back in idle", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;

    // Backpressure for 5 cycles while window 6 is presented.
    fork
      send_frame(0, 1'b0);
      begin : bp
        int guard;
        guard = 0;
        while (!(o_valid && out_cnt == NPIX + 6) && guard < 300) begin
          @(posedge clk);
          #1;
          guard++;
        end
        check("stall reached w6", 32'(o_valid && out_cnt == NPIX + 6), 32'd1);
        i_ready = 1'b0;
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        i_ready = 1'b1;
      end
    join
    wait_out(2 * NPIX);
    check_literals(0);

    // Input gaps: i_valid alternates.
    send_frame(0, 1'b1);
    wait_out(3 * NPIX);
    check_literals(0);

    // Reset after 9 pixels, then a fresh frame 101..116.
    for (int i = 0; i < 9; i++) send_pixel(i + 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    check_reset_outputs();
    release_reset();
    send_frame(100, 1'b0);
    wait_out(NPIX);
    check_literals(100);

    // Back-to-back frames; the second frame's first pixel waits through flush.
    send_frame(200, 1'b0);
    send_frame(300, 1'b0);
    wait_out(3 * NPIX);
    check_literals(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
